// File: rtl/request_queue_if.sv
// Request/dequeue bundle between the trace parser, the request queue and the
// command scheduler. Signal names follow the parser/scheduler netlist.
interface request_queue_if #(
  parameter int ADDRESS_WIDTH = 33,
  parameter int TIME_WIDTH    = 32,
  parameter int DEPTH         = 16
);
  localparam int OCC_WIDTH = $clog2(DEPTH + 1);

  // Handshakes: the parser holds in_* stable while pending_request is high;
  // the head transfers on any cycle where deq_valid and deq_ready are both 1.
  logic                     in_valid;
  logic [1:0]               in_opcode;
  logic [ADDRESS_WIDTH-1:0] in_address;
  logic [TIME_WIDTH-1:0]    in_time;
  logic [TIME_WIDTH-1:0]    queue_time;
  logic                     queue_full;
  logic                     pending_request;
  logic                     deq_valid;
  logic [1:0]               deq_opcode;
  logic [ADDRESS_WIDTH-1:0] deq_address;
  logic [TIME_WIDTH-1:0]    deq_time;
  logic                     deq_ready;
  logic [OCC_WIDTH-1:0]     occupancy;

  modport slave (
    input  in_valid, in_opcode, in_address, in_time, deq_ready,
    output queue_time, queue_full, pending_request,
    output deq_valid, deq_opcode, deq_address, deq_time, occupancy
  );

  modport master (
    output in_valid, in_opcode, in_address, in_time, deq_ready,
    input  queue_time, queue_full, pending_request,
    input  deq_valid, deq_opcode, deq_address, deq_time, occupancy
  );
endinterface

// File: rtl/request_queue.sv
// Time-gated in-order request queue: admits parser requests once simulated
// time reaches their CPU time and presents the oldest one to the scheduler.
module request_queue #(
  parameter int ADDRESS_WIDTH = 33,
  parameter int TIME_WIDTH    = 32,
  parameter int DEPTH         = 16
) (
  input logic             clk,
  input logic             rst,
  request_queue_if.slave  bus
);
  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam int OCC_WIDTH = $clog2(DEPTH + 1);
  localparam logic [1:0] OP_NOP = 2'd3;

  logic [PTR_WIDTH-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]     rd_ptr_q, rd_ptr_d;
  logic [OCC_WIDTH-1:0]     occ_q, occ_d;
  logic [TIME_WIDTH-1:0]    time_q, time_d;
  logic                     full_q, full_d;
  logic                     pend_q, pend_d;

  logic [1:0]               op_mem   [DEPTH];
  logic [ADDRESS_WIDTH-1:0] addr_mem [DEPTH];
  logic [TIME_WIDTH-1:0]    time_mem [DEPTH];

  logic empty;
  logic accept;
  logic enq;
  logic deq_fire;
  logic skip_ahead;

  always_comb begin
    empty      = (occ_q == '0);
    accept     = bus.in_valid && (bus.in_time <= time_q) && !full_q;
    // NOPs advance the parser but never occupy a slot.
    enq        = accept && (bus.in_opcode != OP_NOP);
    deq_fire   = !empty && bus.deq_ready;
    skip_ahead = empty && bus.in_valid && (bus.in_time > time_q);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (enq) begin
      wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
    end
    if (deq_fire) begin
      rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
    end
    case ({enq, deq_fire})
      2'b10:   occ_d = occ_q + OCC_WIDTH'(1);
      2'b01:   occ_d = occ_q - OCC_WIDTH'(1);
      default: occ_d = occ_q;
    endcase
    full_d = (occ_d == OCC_WIDTH'(DEPTH));
    pend_d = bus.in_valid && !accept;
  end

  // With nothing queued there is no reason to tick through idle time, so jump
  // straight to the waiting request; otherwise advance one step, saturating.
  always_comb begin
    time_d = time_q;
    if (skip_ahead) begin
      time_d = bus.in_time;
    end else if (time_q != '1) begin
      time_d = time_q + TIME_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      time_q   <= '0;
      full_q   <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      time_q   <= time_d;
      full_q   <= full_d;
      pend_q   <= pend_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (!rst && enq) begin
      op_mem[wr_ptr_q]   <= bus.in_opcode;
      addr_mem[wr_ptr_q] <= bus.in_address;
      time_mem[wr_ptr_q] <= bus.in_time;
    end
  end

  assign bus.queue_time      = time_q;
  assign bus.queue_full      = full_q;
  assign bus.pending_request = pend_q;
  assign bus.occupancy       = occ_q;
  assign bus.deq_valid       = !empty;
  assign bus.deq_opcode      = empty ? 2'd0 : op_mem[rd_ptr_q];
  assign bus.deq_address     = empty ? '0 : addr_mem[rd_ptr_q];
  assign bus.deq_time        = empty ? '0 : time_mem[rd_ptr_q];
endmodule

// File: tb/tb_request_queue.sv
// Directed bench for request_queue: reset, skip-ahead, fill/back-pressure,
// streaming wrap, NOPs, mid-run reset and time saturation.
module tb_request_queue;
  localparam int AW    = 33;
  localparam int TW    = 32;
  localparam int DEPTH = 16;

  logic clk;
  logic rst;
  int   vec_cnt;
  int   err_cnt;
  logic [AW-1:0] exp_q[$];

  request_queue_if #(.ADDRESS_WIDTH(AW), .TIME_WIDTH(TW), .DEPTH(DEPTH)) rq_if ();

  request_queue #(.ADDRESS_WIDTH(AW), .TIME_WIDTH(TW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (rq_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic v, input logic [1:0] op, input logic [AW-1:0] a,
                           input logic [TW-1:0] t);
    rq_if.in_valid   = v;
    rq_if.in_opcode  = op;
    rq_if.in_address = a;
    rq_if.in_time    = t;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_qtime"}, 64'(rq_if.queue_time), 64'd0);
    check_val({tag, "_full"}, 64'(rq_if.queue_full), 64'd0);
    check_val({tag, "_pend"}, 64'(rq_if.pending_request), 64'd0);
    check_val({tag, "_dvalid"}, 64'(rq_if.deq_valid), 64'd0);
    check_val({tag, "_dop"}, 64'(rq_if.deq_opcode), 64'd0);
    check_val({tag, "_daddr"}, 64'(rq_if.deq_address), 64'd0);
    check_val({tag, "_dtime"}, 64'(rq_if.deq_time), 64'd0);
    check_val({tag, "_occ"}, 64'(rq_if.occupancy), 64'd0);
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst = 1'b1;
    rq_if.deq_ready = 1'b0;
    drive_req(1'b0, 2'd0, '0, '0);

    // 1: reset behaviour
    step();
    check_idle_outputs("rst_c1");
    step();
    check_idle_outputs("rst_c2");
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check_val("rst_qtime_count", 64'(rq_if.queue_time), 64'(i));
    end

    // 2: skip-ahead then admission at queue_time == in_time
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive_req(1'b1, 2'd0, 33'h1_2345_6780, 32'd5);
    step();
    check_val("skip_pend", 64'(rq_if.pending_request), 64'd1);
    check_val("skip_qtime", 64'(rq_if.queue_time), 64'd5);
    check_val("skip_occ0", 64'(rq_if.occupancy), 64'd0);
    step();
    drive_req(1'b0, 2'd0, '0, '0);
    check_val("adm_pend", 64'(rq_if.pending_request), 64'd0);
    check_val("adm_occ", 64'(rq_if.occupancy), 64'd1);
    check_val("adm_dvalid", 64'(rq_if.deq_valid), 64'd1);
    check_val("adm_daddr", 64'(rq_if.deq_address), 64'h1_2345_6780);
    check_val("adm_dtime", 64'(rq_if.deq_time), 64'd5);
    check_val("adm_dop", 64'(rq_if.deq_opcode), 64'd0);
    check_val("adm_qtime", 64'(rq_if.queue_time), 64'd6);
    rq_if.deq_ready = 1'b1;
    step();
    rq_if.deq_ready = 1'b0;
    check_val("adm_drain_dvalid", 64'(rq_if.deq_valid), 64'd0);
    check_val("adm_drain_daddr", 64'(rq_if.deq_address), 64'd0);

    // 3: fill to DEPTH, back-pressure the 17th, release with one dequeue
    for (int i = 0; i < DEPTH; i++) begin
      drive_req(1'b1, 2'(i % 3), AW'(i), 32'd0);
      exp_q.push_back(AW'(i));
      step();
    end
    check_val("fill_full", 64'(rq_if.queue_full), 64'd1);
    check_val("fill_occ", 64'(rq_if.occupancy), 64'd16);
    check_val("fill_pend_before", 64'(rq_if.pending_request), 64'd0);
    drive_req(1'b1, 2'd1, 33'h10, 32'd0);
    step();
    check_val("bp_pend1", 64'(rq_if.pending_request), 64'd1);
    step();
    check_val("bp_pend2", 64'(rq_if.pending_request), 64'd1);
    check_val("bp_occ", 64'(rq_if.occupancy), 64'd16);
    check_val("bp_head0", 64'(rq_if.deq_address), 64'(exp_q.pop_front()));
    rq_if.deq_ready = 1'b1;
    step();
    rq_if.deq_ready = 1'b0;
    check_val("bp_full_drop", 64'(rq_if.queue_full), 64'd0);
    check_val("bp_occ15", 64'(rq_if.occupancy), 64'd15);
    check_val("bp_pend_still", 64'(rq_if.pending_request), 64'd1);
    step();
    exp_q.push_back(33'h10);
    drive_req(1'b0, 2'd0, '0, '0);
    check_val("bp_accept_pend", 64'(rq_if.pending_request), 64'd0);
    check_val("bp_accept_occ", 64'(rq_if.occupancy), 64'd16);
    check_val("bp_accept_full", 64'(rq_if.queue_full), 64'd1);
    for (int i = 1; i <= DEPTH; i++) begin
      check_val("drain_order", 64'(rq_if.deq_address), 64'(exp_q.pop_front()));
      check_val("drain_op", 64'(rq_if.deq_opcode), (i == DEPTH) ? 64'd1 : 64'(i % 3));
      rq_if.deq_ready = 1'b1;
      step();
    end
    rq_if.deq_ready = 1'b0;
    check_val("drain_empty", 64'(rq_if.deq_valid), 64'd0);

    // 4: steady state at occupancy 3 with enqueue and dequeue every cycle
    for (int i = 0; i < 3; i++) begin
      drive_req(1'b1, 2'd2, AW'(33'h100 + i), 32'd0);
      exp_q.push_back(AW'(33'h100 + i));
      step();
    end
    check_val("ss_prefill_occ", 64'(rq_if.occupancy), 64'd3);
    rq_if.deq_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check_val("ss_head", 64'(rq_if.deq_address), 64'(exp_q.pop_front()));
      drive_req(1'b1, 2'd0, AW'(33'h1_0000_0200 + i), 32'd0);
      exp_q.push_back(AW'(33'h1_0000_0200 + i));
      step();
      check_val("ss_occ", 64'(rq_if.occupancy), 64'd3);
    end
    drive_req(1'b0, 2'd0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      check_val("ss_tail", 64'(rq_if.deq_address), 64'(exp_q.pop_front()));
      step();
    end
    rq_if.deq_ready = 1'b0;
    check_val("ss_empty_occ", 64'(rq_if.occupancy), 64'd0);

    // 5: NOPs are consumed without occupying a slot
    drive_req(1'b1, 2'd3, 33'h55, 32'd0);
    step();
    check_val("nop_pend", 64'(rq_if.pending_request), 64'd0);
    check_val("nop_occ", 64'(rq_if.occupancy), 64'd0);
    check_val("nop_dvalid", 64'(rq_if.deq_valid), 64'd0);
    drive_req(1'b1, 2'd1, 33'h66, 32'd0);
    step();
    drive_req(1'b1, 2'd3, 33'h77, 32'd0);
    step();
    drive_req(1'b0, 2'd0, '0, '0);
    check_val("nop2_occ", 64'(rq_if.occupancy), 64'd1);
    check_val("nop2_pend", 64'(rq_if.pending_request), 64'd0);
    check_val("nop2_head", 64'(rq_if.deq_address), 64'h66);
    rq_if.deq_ready = 1'b1;
    step();
    rq_if.deq_ready = 1'b0;

    // 6: reset with entries queued and a request held off by time
    for (int i = 0; i < 5; i++) begin
      drive_req(1'b1, 2'd0, AW'(33'h300 + i), 32'd0);
      step();
    end
    drive_req(1'b1, 2'd0, 33'h3FF, 32'hFFFF_FF00);
    step();
    check_val("mr_pre_occ", 64'(rq_if.occupancy), 64'd5);
    check_val("mr_pre_pend", 64'(rq_if.pending_request), 64'd1);
    rst = 1'b1;
    step();
    check_val("mr_occ", 64'(rq_if.occupancy), 64'd0);
    check_val("mr_dvalid", 64'(rq_if.deq_valid), 64'd0);
    check_val("mr_pend", 64'(rq_if.pending_request), 64'd0);
    check_val("mr_qtime", 64'(rq_if.queue_time), 64'd0);
    rst = 1'b0;
    drive_req(1'b0, 2'd0, '0, '0);
    for (int i = 1; i <= 3; i++) begin
      step();
      check_val("mr_after_dvalid", 64'(rq_if.deq_valid), 64'd0);
      check_val("mr_after_qtime", 64'(rq_if.queue_time), 64'(i));
    end
    drive_req(1'b1, 2'd2, 33'h4AA, 32'd0);
    step();
    drive_req(1'b0, 2'd0, '0, '0);
    check_val("mr_fresh_occ", 64'(rq_if.occupancy), 64'd1);
    check_val("mr_fresh_head", 64'(rq_if.deq_address), 64'h4AA);
    check_val("mr_fresh_op", 64'(rq_if.deq_opcode), 64'd2);
    rq_if.deq_ready = 1'b1;
    step();
    rq_if.deq_ready = 1'b0;

    // time base saturates at all-ones after a skip to the maximum
    drive_req(1'b1, 2'd0, 33'h1_FFFF_FFFF, 32'hFFFF_FFFF);
    step();
    check_val("sat_skip_qtime", 64'(rq_if.queue_time), 64'hFFFF_FFFF);
    check_val("sat_skip_pend", 64'(rq_if.pending_request), 64'd1);
    step();
    drive_req(1'b0, 2'd0, '0, '0);
    check_val("sat_hold_qtime", 64'(rq_if.queue_time), 64'hFFFF_FFFF);
    check_val("sat_occ", 64'(rq_if.occupancy), 64'd1);
    check_val("sat_daddr", 64'(rq_if.deq_address), 64'h1_FFFF_FFFF);
    check_val("sat_dtime", 64'(rq_if.deq_time), 64'hFFFF_FFFF);
    step();
    check_val("sat_hold2_qtime", 64'(rq_if.queue_time), 64'hFFFF_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/request_queue.md
# request_queue

Receiving end of the trace parser's request interface in the DRAM controller simulator. The block takes parsed CPU requests (opcode, address, CPU time) and owns the simulation time base (`queue_time`). It admits a request only once simulated time has reached that request's CPU time. Admitted requests are buffered in a 16-entry in-order queue, and the head entry is presented to the downstream command scheduler with a valid/ready handshake. Back-pressure to the parser is driven through `queue_full` and `pending_request`.

## Interface
- `ADDRESS_WIDTH`, 33, request address width.
- `TIME_WIDTH`, 32, width of CPU time and `queue_time`.
- `DEPTH`, 16, queue entries; must be a power of 2.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  parser has a request on `in_*` (parser `op_ready_s`).
- `in_opcode`  in  2  0 = data read, 1 = data write, 2 = instruction fetch, 3 = NOP.
- `in_address`  in  ADDRESS_WIDTH  request address.
- `in_time`  in  TIME_WIDTH  CPU time of the request.
- `queue_time`  out  TIME_WIDTH  current simulated time, registered.
- `queue_full`  out  1  occupancy == DEPTH, registered.
- `pending_request`  out  1  presented request not yet taken, registered.
- `deq_valid`  out  1  head entry valid.
- `deq_opcode`  out  2  head opcode.
- `deq_address`  out  ADDRESS_WIDTH  head address.
- `deq_time`  out  TIME_WIDTH  head CPU time (the `in_time` captured at admission).
- `deq_ready`  in  1  scheduler takes the head this cycle.
- `occupancy`  out  $clog2(DEPTH+1)  entries held.

## Operation
- **Accept condition.** `accept = in_valid && (in_time <= queue_time) && !queue_full`.
  - Accepted opcodes 0–2 are written at the write pointer.
  - An accepted NOP is consumed and writes nothing.
- **Pending request.**
  - `pending_request <= in_valid && !accept`.
  - The parser holds its request while this is 1. The register exists so there is no combinational path back into `op_ready_s`.
- **Dequeue.**
  - `deq_fire = deq_valid && deq_ready`.
  - The read pointer advances on `deq_fire`.
  - `deq_ready` is ignored when the queue is empty.
- **Occupancy and pointers.**
  - `occupancy` changes by +1 on enqueue only, −1 on dequeue only, and is unchanged on both or neither.
  - Pointers wrap modulo DEPTH.
  - When full, enqueue is refused even if a dequeue fires in the same cycle. There is no bypass.
- **Time base.**
  - Normal case: `queue_time <= queue_time + 1`, saturating at all-ones.
  - Skip-ahead: when `occupancy == 0`, `in_valid == 1` and `in_time > queue_time`, then `queue_time <= in_time`.
- **Head outputs.**
  - `deq_valid = (occupancy != 0)`.
  - The `deq_*` data outputs come from head storage and are forced to 0 when the queue is empty.
- **Ordering.** Strict FIFO; no reordering.
- **Reset.**
  - Clears pointers, `occupancy`, `queue_time`, `queue_full` and `pending_request` to 0.
  - `deq_valid` and all `deq_*` outputs are therefore 0.
  - Reset mid-operation discards all entries, and any held parser request is not accepted during reset.

## Timing
- Enqueue latency:
  - A request accepted in cycle N sets `deq_valid` in cycle N+1 if the queue was empty.
  - Occupancy updates at N+1.
- `queue_full` asserts in the cycle after the DEPTH-th enqueue. It deasserts in the cycle after the first dequeue from full.
- `pending_request`:
  - It rises one cycle after a refused presentation.
  - It falls one cycle after acceptance.
- Skip-ahead takes effect one cycle after detection. The request is then accepted in the next cycle, when `queue_time == in_time`.
- Dequeue: the head changes in the cycle after `deq_fire`.
- All outputs are registered, except `deq_valid` and `deq_*`, which are decoded from registered state with no input-to-output path.

## Test plan
1. **Reset behaviour.**
   - Stimulus: hold `rst` high for 2 cycles, then release with no input.
   - Required: all outputs are 0 during reset; `queue_time` reads 1, 2, 3 on successive cycles after release.
2. **Skip-ahead and single admission.**
   - Stimulus: with the queue empty and `queue_time` = 0, present opcode 0, address 0x1_2345_6780, `in_time` = 5.
   - Required: `pending_request` = 1 and `queue_time` = 5 in the next cycle; acceptance follows; `deq_valid` = 1 with address 0x1_2345_6780 and `deq_time` = 5.
3. **Fill and back-pressure.**
   - Stimulus: with `deq_ready` = 0, present 17 requests with `in_time` = 0 and addresses 0x0..0x10.
   - Required: `queue_full` = 1 after the 16th; `pending_request` stays 1 for the 17th.
   - Stimulus: pulse `deq_ready` for one cycle.
   - Required: head 0x0 leaves; the 17th request is accepted one cycle after `queue_full` drops; subsequent dequeues yield 0x1..0x10 in order.
4. **Simultaneous enqueue/dequeue and wrap.**
   - Stimulus: hold occupancy at 3 with `deq_ready` = 1 and one enqueue per cycle for 20 cycles.
   - Required: occupancy stays 3 throughout; pointers wrap; output order equals input order.
5. **NOP handling.**
   - Stimulus: present opcode 3 with `in_time` ≤ `queue_time`.
   - Required: `pending_request` stays 0; occupancy is unchanged; `deq_valid` stays 0 if the queue was empty.
6. **Reset mid-operation.**
   - Stimulus: with 5 entries queued and a pending request held, assert `rst` for 1 cycle.
   - Required: occupancy 0, `deq_valid` 0, `pending_request` 0 and `queue_time` 0 in the next cycle; no stale entry appears afterwards.
